// File: rtl/wishbone_sdram_adapter.sv
// Wishbone classic slave that turns each single-beat cycle into one SDRAM controller command.
// Out-of-range addresses and stalled commands end with wb_err so the master never hangs.
module wishbone_sdram_adapter #(
    parameter int unsigned ADDR_WIDTH = 24,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                  clk_sys,
    input  logic                  reset_n,
    input  logic [29:0]           wb_adr,
    input  logic [31:0]           wb_dat_w,
    output logic [31:0]           wb_dat_r,
    input  logic [3:0]            wb_sel,
    input  logic                  wb_cyc,
    input  logic                  wb_stb,
    input  logic                  wb_we,
    input  logic [2:0]            wb_cti,
    input  logic [1:0]            wb_bte,
    output logic                  wb_ack,
    output logic                  wb_err,
    output logic                  cmd_valid,
    input  logic                  cmd_ready,
    output logic                  cmd_we,
    output logic [ADDR_WIDTH-1:0] cmd_addr,
    output logic [31:0]           cmd_wdata,
    output logic [3:0]            cmd_mask,
    input  logic                  rd_valid,
    input  logic [31:0]           rd_data,
    output logic                  busy
);

    typedef enum logic [2:0] {StIdle, StIssue, StWaitRd, StResp, StErr, StGap} state_e;

    localparam logic [15:0] TimeoutLast = 16'(TIMEOUT - 1);

    state_e                state_q, state_d;
    logic                  cmd_valid_q, cmd_valid_d;
    logic                  cmd_we_q, cmd_we_d;
    logic [ADDR_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
    logic [31:0]           cmd_wdata_q, cmd_wdata_d;
    logic [3:0]            cmd_mask_q, cmd_mask_d;
    logic [31:0]           dat_r_q, dat_r_d;
    logic [15:0]           cnt_q, cnt_d;
    logic                  abort_q, abort_d;

    logic in_range, handshake, timeout_hit, aborting;
    logic unused_bus;

    // Bursts are not supported, so cycle type and burst extension carry no information.
    assign unused_bus  = ^{wb_cti, wb_bte};

    assign in_range    = (wb_adr >> ADDR_WIDTH) == 30'd0;
    assign handshake   = cmd_valid_q & cmd_ready;
    assign timeout_hit = cnt_q == TimeoutLast;
    assign aborting    = abort_q | ~wb_cyc;

    always_comb begin
        state_d     = state_q;
        cmd_valid_d = cmd_valid_q;
        cmd_we_d    = cmd_we_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        cmd_mask_d  = cmd_mask_q;
        dat_r_d     = dat_r_q;
        cnt_d       = cnt_q;
        abort_d     = abort_q;
        unique case (state_q)
            StIdle: begin
                if (wb_cyc && wb_stb) begin
                    if (!in_range) begin
                        state_d = StErr;
                    end else begin
                        cmd_we_d    = wb_we;
                        cmd_addr_d  = wb_adr[ADDR_WIDTH-1:0];
                        cmd_wdata_d = wb_dat_w;
                        cmd_mask_d  = wb_sel;
                        cmd_valid_d = 1'b1;
                        cnt_d       = '0;
                        abort_d     = 1'b0;
                        state_d     = StIssue;
                    end
                end
            end
            StIssue: begin
                cnt_d   = cnt_q + 16'd1;
                abort_d = aborting;
                if (handshake) begin
                    cmd_valid_d = 1'b0;
                    if (!cmd_we_q) begin
                        state_d = StWaitRd;
                    end else begin
                        state_d = aborting ? StGap : StResp;
                    end
                end else if (timeout_hit) begin
                    cmd_valid_d = 1'b0;
                    state_d     = aborting ? StGap : StErr;
                end
            end
            StWaitRd: begin
                cnt_d   = cnt_q + 16'd1;
                abort_d = aborting;
                if (rd_valid) begin
                    // An abandoned read still drains its data, but the result is dropped.
                    if (!aborting) begin
                        dat_r_d = rd_data;
                        state_d = StResp;
                    end else begin
                        state_d = StGap;
                    end
                end else if (timeout_hit) begin
                    state_d = aborting ? StGap : StErr;
                end
            end
            StResp:  state_d = StGap;
            StErr:   state_d = StGap;
            StGap:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            cmd_valid_q <= 1'b0;
            cmd_we_q    <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            cmd_mask_q  <= '0;
            dat_r_q     <= '0;
            cnt_q       <= '0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_we_q    <= cmd_we_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
            cmd_mask_q  <= cmd_mask_d;
            dat_r_q     <= dat_r_d;
            cnt_q       <= cnt_d;
            abort_q     <= abort_d;
        end
    end

    // Gating with wb_cyc keeps a response from reaching a master that has already left.
    assign wb_ack    = (state_q == StResp) & wb_cyc;
    assign wb_err    = (state_q == StErr) & wb_cyc;
    assign busy      = state_q != StIdle;
    assign wb_dat_r  = dat_r_q;
    assign cmd_valid = cmd_valid_q;
    assign cmd_we    = cmd_we_q;
    assign cmd_addr  = cmd_addr_q;
    assign cmd_wdata = cmd_wdata_q;
    assign cmd_mask  = cmd_mask_q;

endmodule

// File: tb/tb_wishbone_sdram_adapter.sv
// Bench for wishbone_sdram_adapter: bridge-master stimulus, SDRAM controller model and a
// scoreboard checking commands and Wishbone responses against a transaction-level model.
module tb_wishbone_sdram_adapter;

    localparam int AW = 24;

    logic        clk_sys, reset_n;
    logic [29:0] wb_adr;
    logic [31:0] wb_dat_w, wb_dat_r;
    logic [3:0]  wb_sel;
    logic        wb_cyc, wb_stb, wb_we;
    logic [2:0]  wb_cti;
    logic [1:0]  wb_bte;
    logic        wb_ack, wb_err;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [AW-1:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_mask;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        busy;

    wishbone_sdram_adapter #(.ADDR_WIDTH(AW), .TIMEOUT(16)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .wb_adr(wb_adr), .wb_dat_w(wb_dat_w),
        .wb_dat_r(wb_dat_r), .wb_sel(wb_sel), .wb_cyc(wb_cyc), .wb_stb(wb_stb),
        .wb_we(wb_we), .wb_cti(wb_cti), .wb_bte(wb_bte), .wb_ack(wb_ack), .wb_err(wb_err),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata), .cmd_mask(cmd_mask), .rd_valid(rd_valid), .rd_data(rd_data),
        .busy(busy)
    );

    typedef struct {
        bit          we;
        logic [23:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        int          at;
    } cmd_t;

    typedef struct {
        bit          err;
        logic [31:0] dat;
        int          at;
    } rsp_t;

    cmd_t        cmd_q[$];
    rsp_t        rsp_q[$];
    logic [31:0] ref_mem[int unsigned];
    logic [31:0] ctl_mem[int unsigned];
    logic [31:0] last_rd;
    int          checks, passed, cyc_cnt;
    int          ctl_mode, fix_stall, fix_lat;
    bit          hold_rd;

    initial begin
        clk_sys = 1'b0;
        forever #5 clk_sys = ~clk_sys;
    end

    initial cyc_cnt = 0;
    always @(posedge clk_sys) cyc_cnt <= cyc_cnt + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d passed %0d", checks, passed);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [31:0] init_word(input logic [23:0] a);
        return {8'hA5, a};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] sel);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // SDRAM controller model: ready after a stall count, read data after a latency.
    initial begin : ctl
        bit          vld, hs, hs_we, rd_pend;
        logic [23:0] hs_addr, rd_addr;
        logic [31:0] hs_wdata, old;
        logic [3:0]  hs_mask;
        int          seen, stall, lat;
        cmd_ready = 1'b0; rd_valid = 1'b0; rd_data = '0;
        rd_pend = 0; seen = 0; stall = 0; lat = 0; rd_addr = '0;
        forever begin
            @(negedge clk_sys);
            vld = cmd_valid; hs = cmd_valid && cmd_ready;
            hs_we = cmd_we; hs_addr = cmd_addr; hs_wdata = cmd_wdata; hs_mask = cmd_mask;
            @(posedge clk_sys); #1;
            rd_valid = 1'b0;
            rd_data  = $urandom;
            if (hs) begin
                old = ctl_mem.exists(32'(hs_addr)) ? ctl_mem[32'(hs_addr)] : init_word(hs_addr);
                if (hs_we) ctl_mem[32'(hs_addr)] = merge(old, hs_wdata, hs_mask);
                else begin
                    rd_pend = 1; rd_addr = hs_addr;
                    lat = (fix_lat >= 0) ? fix_lat : int'($urandom_range(1, 4));
                end
            end
            if (rd_pend && !hold_rd) begin
                lat--;
                if (lat <= 0) begin
                    rd_valid = 1'b1;
                    rd_data  = ctl_mem.exists(32'(rd_addr)) ? ctl_mem[32'(rd_addr)]
                                                            : init_word(rd_addr);
                    rd_pend  = 0;
                end
            end
            if (hs || !vld) begin
                seen  = 0;
                stall = (fix_stall >= 0) ? fix_stall : int'($urandom_range(0, 5));
            end else begin
                seen++;
            end
            cmd_ready = (ctl_mode == 0) && (seen >= stall);
        end
    end

    // Scoreboard monitor.
    initial begin : monitor
        logic [60:0] prev_f, cur_f;
        bit          prev_stall;
        cmd_t        c;
        rsp_t        r;
        prev_stall = 0; prev_f = '0;
        forever begin
            @(negedge clk_sys);
            if (!reset_n) begin
                prev_stall = 0;
            end else begin
                cur_f = {cmd_we, cmd_addr, cmd_wdata, cmd_mask};
                if (prev_stall && cmd_valid) chk("cmd_stable", 64'(cur_f), 64'(prev_f));
                prev_stall = cmd_valid && !cmd_ready;
                prev_f     = cur_f;
                if (cmd_valid && cmd_ready) begin
                    chk("cmd_expected", 64'(cmd_q.size() != 0), 64'(1));
                    if (cmd_q.size() != 0) begin
                        c = cmd_q.pop_front();
                        chk("cmd_we", 64'(cmd_we), 64'(c.we));
                        chk("cmd_addr", 64'(cmd_addr), 64'(c.addr));
                        chk("cmd_wdata", 64'(cmd_wdata), 64'(c.wdata));
                        chk("cmd_mask", 64'(cmd_mask), 64'(c.mask));
                        if (c.at >= 0) chk("cmd_cycle", 64'(cyc_cnt), 64'(c.at));
                    end
                end
                if (wb_ack || wb_err) begin
                    chk("ack_err_exclusive", 64'(wb_ack && wb_err), 64'(0));
                    chk("resp_with_cyc", 64'(wb_cyc), 64'(1));
                    chk("resp_expected", 64'(rsp_q.size() != 0), 64'(1));
                    if (rsp_q.size() != 0) begin
                        r = rsp_q.pop_front();
                        chk("resp_is_err", 64'(wb_err), 64'(r.err));
                        if (!r.err) chk("wb_dat_r", 64'(wb_dat_r), 64'(r.dat));
                        if (r.at >= 0) chk("resp_cycle", 64'(cyc_cnt), 64'(r.at));
                    end
                end
            end
        end
    end

    // kind: 0 normal, 1 master abort after one cycle, 2 expected timeout.
    task automatic wb_xfer(input bit we, input logic [29:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input int cmd_lat, input int rsp_lat,
                           input int kind);
        cmd_t        c;
        rsp_t        r;
        int          n;
        bit          got;
        int unsigned key;
        logic [31:0] old;
        @(posedge clk_sys); #1;
        n = cyc_cnt;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_dat_w = dat; wb_sel = sel;
        wb_cti = ($urandom_range(0, 1) == 1) ? 3'd7 : 3'd0;
        wb_bte = 2'($urandom);
        r.at = (rsp_lat < 0) ? -1 : n + rsp_lat;
        r.err = 1; r.dat = '0;
        if (adr < 30'(1 << AW) && kind != 2) begin
            key = 32'(adr[AW-1:0]);
            c.we = we; c.addr = adr[AW-1:0]; c.wdata = dat; c.mask = sel;
            c.at = (cmd_lat < 0) ? -1 : n + cmd_lat;
            cmd_q.push_back(c);
            old = ref_mem.exists(key) ? ref_mem[key] : init_word(adr[AW-1:0]);
            if (we) ref_mem[key] = merge(old, dat, sel);
            else if (kind == 0) last_rd = old;
            r.err = 0; r.dat = last_rd;
        end
        if (kind != 1) rsp_q.push_back(r);
        else begin
            @(posedge clk_sys); #1;
            wb_cyc = 1'b0; wb_stb = 1'b0;
        end
        got = 0;
        for (int k = 0; k < 60 && !got; k++) begin
            @(negedge clk_sys);
            got = (kind == 1) ? !busy : (wb_ack || wb_err);
        end
        chk("resp_seen", 64'(got), 64'(1));
        if (kind == 2) chk("timeout_retract", 64'(cmd_valid), 64'(0));
        if (kind == 1) chk("abort_keeps_dat_r", 64'(wb_dat_r), 64'(last_rd));
        // Strobe stays up one more cycle, as a registered master would leave it.
        @(posedge clk_sys); #1;
    endtask

    task automatic wb_idle(input int n);
        @(posedge clk_sys); #1;
        wb_cyc = 1'b0; wb_stb = 1'b0;
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk({tag, "_ack_err"}, 64'({wb_ack, wb_err}), 64'(0));
        chk({tag, "_cmd_valid"}, 64'(cmd_valid), 64'(0));
        chk({tag, "_cmd_fields"}, 64'({cmd_we, cmd_addr, cmd_mask}), 64'(0));
        chk({tag, "_cmd_wdata"}, 64'(cmd_wdata), 64'(0));
        chk({tag, "_wb_dat_r"}, 64'(wb_dat_r), 64'(0));
    endtask

    initial begin : stim
        bit          got;
        logic [29:0] a;
        cmd_t        c;
        checks = 0; passed = 0; last_rd = '0;
        ctl_mode = 0; fix_stall = 0; fix_lat = -1; hold_rd = 0;
        wb_cyc = 0; wb_stb = 0; wb_we = 0; wb_adr = '0; wb_dat_w = '0; wb_sel = '0;
        wb_cti = '0; wb_bte = '0;
        reset_n = 1'b0;
        repeat (3) @(posedge clk_sys);
        #2;
        chk_all_zero("reset");
        @(posedge clk_sys); #1;
        reset_n = 1'b1;
        wb_idle(2);

        // Single write, always-ready controller.
        wb_xfer(1, 30'h0000123, 32'hDEADBEEF, 4'hF, 1, 2, 0);
        wb_idle(1);
        chk("write_busy_after_gap", 64'(busy), 64'(0));

        // Seed 0x40, then read it back with 5 stall cycles and read latency 3.
        wb_xfer(1, 30'h40, 32'h12345678, 4'hF, 1, 2, 0);
        wb_idle(1);
        fix_stall = 5; fix_lat = 3;
        wb_xfer(0, 30'h40, 32'h0, 4'hF, 6, 10, 0);
        wb_idle(1);

        // Out of range: immediate err, no command.
        fix_stall = 0; fix_lat = -1;
        wb_xfer(0, 30'h1000000, 32'h0, 4'hF, -1, 1, 0);
        wb_idle(1);
        // Highest in-range word, partial-byte write then read.
        wb_xfer(1, 30'h0FFFFFF, 32'hCAFEF00D, 4'h5, 1, 2, 0);
        wb_xfer(0, 30'h0FFFFFF, 32'h0, 4'hF, 1, -1, 0);
        wb_idle(1);

        // Timeout with the controller never ready, then ready on the last counted cycle.
        ctl_mode = 1;
        wb_xfer(1, 30'h10, 32'h11111111, 4'hF, -1, 17, 2);
        wb_idle(1);
        ctl_mode = 0; fix_stall = 15;
        wb_xfer(1, 30'h11, 32'h22222222, 4'hF, 16, 17, 0);
        wb_idle(1);

        // Back-to-back writes, strobe re-raised right after the gap.
        fix_stall = 0;
        for (int i = 0; i < 4; i++) wb_xfer(1, 30'(i), 32'hB0B0_0000 + 32'(i), 4'hF, 1, 2, 0);
        wb_idle(1);

        // Master aborts during a stalled read and a stalled write.
        fix_stall = 3;
        wb_xfer(0, 30'h5, 32'h0, 4'hF, -1, -1, 1);
        wb_xfer(1, 30'h6, 32'h66666666, 4'h3, -1, -1, 1);
        wb_idle(1);

        // Random traffic.
        fix_stall = -1; fix_lat = -1;
        for (int i = 0; i < 60; i++) begin
            a = ($urandom_range(0, 7) == 0) ? (30'h1000000 | 30'($urandom_range(0, 255)))
                                            : 30'($urandom_range(0, 15));
            wb_xfer(1'($urandom), a, $urandom, 4'($urandom), -1, -1, 0);
            if ($urandom_range(0, 2) == 0) wb_idle($urandom_range(0, 2));
        end
        wb_idle(2);

        // Reset while waiting for read data, then the stale rd_valid arrives.
        fix_stall = 0; hold_rd = 1;
        @(posedge clk_sys); #1;
        wb_cyc = 1; wb_stb = 1; wb_we = 0; wb_adr = 30'h7; wb_dat_w = 32'h0; wb_sel = 4'hF;
        c.we = 0; c.addr = 24'h7; c.wdata = 32'h0; c.mask = 4'hF; c.at = -1;
        cmd_q.push_back(c);
        got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk_sys);
            got = busy && !cmd_valid;
        end
        chk("reached_wait_rd", 64'(got), 64'(1));
        #2;
        reset_n = 1'b0;
        wb_cyc = 0; wb_stb = 0;
        #1;
        chk_all_zero("mid_reset");
        @(posedge clk_sys); #1;
        reset_n = 1'b1;
        hold_rd = 0;
        last_rd = '0;
        repeat (8) @(posedge clk_sys);
        #1;
        chk("stale_rd_dat_r", 64'(wb_dat_r), 64'(0));
        chk("stale_rd_idle", 64'(busy), 64'(0));

        wb_idle(3);
        chk("cmd_q_drained", 64'(cmd_q.size()), 64'(0));
        chk("rsp_q_drained", 64'(rsp_q.size()), 64'(0));
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
